// File: rtl/ready_valid_skid_pipeline.sv
// Ready/valid register pipeline of half-buffer or skid-buffer stages,
// with an occupancy count and a synchronous flush.
module ready_valid_skid_pipeline #(
    parameter int DATA_WIDTH     = 8,
    parameter int PIPELINE_DEPTH = 3,
    parameter int MODE           = 1,
    parameter int CNT_W          = $clog2(2*PIPELINE_DEPTH+1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic [CNT_W-1:0]      occupancy
);
    logic                  w_vld [PIPELINE_DEPTH+1];
    logic                  w_rdy [PIPELINE_DEPTH+1];
    logic [DATA_WIDTH-1:0] w_dat [PIPELINE_DEPTH+1];
    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic [CNT_W-1:0]      r_occ;

    // Flush masks both ends so nothing enters or leaves that cycle.
    assign w_vld[0]              = in_valid & ~flush;
    assign w_dat[0]              = in_data;
    assign w_rdy[PIPELINE_DEPTH] = out_ready & ~flush;

    assign in_ready  = w_rdy[0] & reset_n & ~flush;
    assign out_valid = w_vld[PIPELINE_DEPTH] & ~flush;
    assign out_data  = w_dat[PIPELINE_DEPTH];

    for (genvar g = 0; g < PIPELINE_DEPTH; g++) begin : g_stage
        logic w_up_xfer;
        logic w_dn_xfer;

        assign w_up_xfer = w_vld[g] & w_rdy[g];
        assign w_dn_xfer = w_vld[g+1] & w_rdy[g+1];

        if (MODE == 1) begin : g_skid
            logic                  r_main_v;
            logic                  r_skid_v;
            logic [DATA_WIDTH-1:0] r_main_d;
            logic [DATA_WIDTH-1:0] r_skid_d;

            assign w_rdy[g]   = ~r_skid_v;
            assign w_vld[g+1] = r_main_v;
            assign w_dat[g+1] = r_main_d;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_main_v <= 1'b0;
                    r_skid_v <= 1'b0;
                end else if (flush) begin
                    r_main_v <= 1'b0;
                    r_skid_v <= 1'b0;
                end else if (w_dn_xfer) begin
                    r_main_v <= r_skid_v | w_up_xfer;
                    r_skid_v <= 1'b0;
                end else if (w_up_xfer) begin
                    r_main_v <= 1'b1;
                    r_skid_v <= r_main_v;
                end
            end

            always_ff @(posedge clk) begin
                if (w_dn_xfer) begin
                    if (r_skid_v) begin
                        r_main_d <= r_skid_d;
                    end else if (w_up_xfer) begin
                        r_main_d <= w_dat[g];
                    end
                end else if (w_up_xfer) begin
                    if (r_main_v) begin
                        r_skid_d <= w_dat[g];
                    end else begin
                        r_main_d <= w_dat[g];
                    end
                end
            end
        end else begin : g_half
            logic                  r_v;
            logic [DATA_WIDTH-1:0] r_d;

            assign w_rdy[g]   = ~r_v;
            assign w_vld[g+1] = r_v;
            assign w_dat[g+1] = r_d;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_v <= 1'b0;
                end else if (flush) begin
                    r_v <= 1'b0;
                end else if (w_dn_xfer) begin
                    r_v <= 1'b0;
                end else if (w_up_xfer) begin
                    r_v <= 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (w_up_xfer) begin
                    r_d <= w_dat[g];
                end
            end
        end
    end

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occ <= r_occ + CNT_W'(1);
        end else if (w_out_xfer && !w_in_xfer) begin
            r_occ <= r_occ - CNT_W'(1);
        end
    end

    assign occupancy = r_occ;
endmodule

// File: tb/tb_ready_valid_skid_pipeline.sv
// Bench for ready_valid_skid_pipeline: skid (index 0) and half-buffer
// (index 1) instances checked against a FIFO model every cycle.
module tb_ready_valid_skid_pipeline;
    localparam int DW = 8;
    localparam int D  = 3;
    localparam int CW = $clog2(2*D+1);

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          iv  [2];
    logic          ir  [2];
    logic          ov  [2];
    logic          orr [2];
    logic [DW-1:0] id  [2];
    logic [DW-1:0] od  [2];
    logic [CW-1:0] occ [2];

    ready_valid_skid_pipeline #(
        .DATA_WIDTH(DW), .PIPELINE_DEPTH(D), .MODE(1)
    ) u_skid (
        .clk(clk), .reset_n(rst_n),
        .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_ready(orr[0]),
        .flush(flush), .occupancy(occ[0])
    );

    ready_valid_skid_pipeline #(
        .DATA_WIDTH(DW), .PIPELINE_DEPTH(D), .MODE(0)
    ) u_half (
        .clk(clk), .reset_n(rst_n),
        .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_ready(orr[1]),
        .flush(flush), .occupancy(occ[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: items between rp and wp are held by the pipeline
    logic [DW-1:0] mq    [2][256];
    int            mac   [2][256];
    bit            shown [2][256];
    int            wp [2];
    int            rp [2];
    int            cap [2];
    bit            hold [2];
    logic [DW-1:0] hd [2];
    bit            acc [2];
    bit            dlv [2];
    int            sent [2];
    int            rcv [2];
    int            fa [2];
    int            fo [2];
    int            fd [2];
    int            ld [2];
    int            ofd [2];
    logic [DW-1:0] stim [256];
    int            nitems;
    int            cyc;
    bit            v_rand;
    bit            r_rand;
    bit            r_hold;
    int            errs;
    int            chks;

    task automatic chk(input string nm, input int act, input int exp);
        chks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic monitor();
        cyc++;
        if (rst_n) begin
            for (int m = 0; m < 2; m++) begin
                int n;
                int k;
                n = wp[m] - rp[m];
                k = rp[m] % 256;
                chk($sformatf("occ[%0d]", m), int'(occ[m]), n);
                if (hold[m] && !flush) begin
                    chk($sformatf("hold_valid[%0d]", m), int'(ov[m]), 1);
                    chk($sformatf("hold_data[%0d]", m), int'(od[m]), int'(hd[m]));
                end
                if (flush) begin
                    chk($sformatf("flush_ir[%0d]", m), int'(ir[m]), 0);
                    chk($sformatf("flush_ov[%0d]", m), int'(ov[m]), 0);
                end
                if (n == cap[m] && !orr[m])
                    chk($sformatf("full_ir[%0d]", m), int'(ir[m]), 0);
                if (n == 0) begin
                    chk($sformatf("empty_ov[%0d]", m), int'(ov[m]), 0);
                end else if (ov[m]) begin
                    chk($sformatf("data[%0d]", m), int'(od[m]), int'(mq[m][k]));
                    if (!shown[m][k]) begin
                        shown[m][k] = 1'b1;
                        chk($sformatf("min_latency[%0d]", m),
                            int'(cyc - mac[m][k] >= D), 1);
                        if (fo[m] < 0) fo[m] = cyc;
                    end
                end
                acc[m] = iv[m] & ir[m];
                dlv[m] = ov[m] & orr[m];
                if (flush) begin
                    rp[m]  = wp[m];
                    acc[m] = 1'b0;
                end else begin
                    if (acc[m]) begin
                        mq[m][wp[m] % 256]    = id[m];
                        mac[m][wp[m] % 256]   = cyc;
                        shown[m][wp[m] % 256] = 1'b0;
                        wp[m]++;
                        if (fa[m] < 0) fa[m] = cyc;
                    end
                    if (dlv[m]) begin
                        if (n > 0) rp[m]++;
                        rcv[m]++;
                        if (fd[m] < 0) begin
                            fd[m]  = cyc;
                            ofd[m] = int'(occ[m]);
                        end
                        ld[m] = cyc;
                    end
                end
                hold[m] = ov[m] & ~orr[m] & ~flush;
                hd[m]   = od[m];
            end
        end
    endtask

    task automatic drive();
        for (int m = 0; m < 2; m++) begin
            if (acc[m]) sent[m]++;
            acc[m] = 1'b0;
            iv[m]  = (sent[m] < nitems) &&
                     (!v_rand || $urandom_range(0, 1) == 1);
            id[m]  = stim[sent[m] % 256];
            orr[m] = !r_hold && (!r_rand || $urandom_range(0, 1) == 1);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic start_stream(input int n, input bit vr, input bit rr);
        nitems = n;
        v_rand = vr;
        r_rand = rr;
        for (int i = 0; i < 256; i++) stim[i] = DW'($urandom);
        for (int m = 0; m < 2; m++) begin
            sent[m] = 0;
            rcv[m]  = 0;
            fa[m]   = -1;
            fo[m]   = -1;
            fd[m]   = -1;
            ld[m]   = -1;
            ofd[m]  = -1;
        end
        drive();
    endtask

    function automatic bit done();
        return sent[0] == nitems && sent[1] == nitems &&
               wp[0] == rp[0] && wp[1] == rp[1];
    endfunction

    task automatic run_until_done(input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            if (done()) break;
            cycle();
        end
        chk({nm, "_complete"}, int'(done()), 1);
    endtask

    initial begin
        errs   = 0;
        chks   = 0;
        cyc    = 0;
        nitems = 0;
        v_rand = 1'b0;
        r_rand = 1'b0;
        r_hold = 1'b0;
        rst_n  = 1'b0;
        flush  = 1'b0;
        cap[0] = 2*D;
        cap[1] = D;
        for (int m = 0; m < 2; m++) begin
            iv[m]   = 1'b0;
            orr[m]  = 1'b0;
            id[m]   = '0;
            wp[m]   = 0;
            rp[m]   = 0;
            hold[m] = 1'b0;
            acc[m]  = 1'b0;
            sent[m] = 0;
        end

        // reset state
        #3;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rst_ov[%0d]", m), int'(ov[m]), 0);
            chk($sformatf("rst_occ[%0d]", m), int'(occ[m]), 0);
            chk($sformatf("rst_ir[%0d]", m), int'(ir[m]), 0);
        end
        #9 rst_n = 1'b1;
        #1;
        for (int m = 0; m < 2; m++)
            chk($sformatf("ir_after_rst[%0d]", m), int'(ir[m]), 1);
        @(posedge clk);
        #1;

        // perfect sender and receiver
        start_stream(16, 1'b0, 1'b0);
        run_until_done(200, "perfect");
        chk("perfect_rcv[0]", rcv[0], 16);
        chk("perfect_rcv[1]", rcv[1], 16);
        chk("perfect_lat[0]", fo[0] - fa[0], 3);
        chk("perfect_lat[1]", fo[1] - fa[1], 3);
        chk("perfect_occ[0]", ofd[0], 3);
        chk("perfect_span[0]", ld[0] - fd[0], 15);

        // busy receiver for 8 cycles
        r_hold = 1'b1;
        start_stream(16, 1'b0, 1'b0);
        repeat (8) cycle();
        chk("busy_acc[0]", sent[0], 6);
        chk("busy_occ[0]", int'(occ[0]), 6);
        chk("busy_ir[0]", int'(ir[0]), 0);
        chk("busy_acc[1]", sent[1], 3);
        chk("busy_occ[1]", int'(occ[1]), 3);
        chk("busy_ir[1]", int'(ir[1]), 0);
        r_hold = 1'b0;
        orr[0] = 1'b1;
        orr[1] = 1'b1;
        run_until_done(300, "busy");
        chk("busy_rcv[0]", rcv[0], 16);
        chk("busy_rcv[1]", rcv[1], 16);
        chk("busy_span[0]", ld[0] - fd[0], 15);
        chk("busy_span[1]", ld[1] - fd[1], 30);

        // random valid and ready
        start_stream(200, 1'b1, 1'b1);
        run_until_done(5000, "random");
        chk("random_rcv[0]", rcv[0], 200);
        chk("random_rcv[1]", rcv[1], 200);

        // flush with four held entries
        r_hold = 1'b1;
        start_stream(8, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (sent[0] == 4) break;
        end
        chk("pre_flush_occ[0]", int'(occ[0]), 4);
        r_hold = 1'b0;
        flush  = 1'b1;
        orr[0] = 1'b1;
        orr[1] = 1'b1;
        #2;
        chk("flush_in_valid[0]", int'(iv[0]), 1);
        chk("flushing_ir[0]", int'(ir[0]), 0);
        chk("flushing_ov[0]", int'(ov[0]), 0);
        cycle();
        flush = 1'b0;
        #1;
        chk("post_flush_occ[0]", int'(occ[0]), 0);
        chk("post_flush_ov[0]", int'(ov[0]), 0);
        chk("post_flush_ir[0]", int'(ir[0]), 1);
        run_until_done(200, "flush");

        // flush of an empty pipeline
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        #1;
        chk("empty_flush_occ[0]", int'(occ[0]), 0);
        chk("empty_flush_ir[0]", int'(ir[0]), 1);

        // async reset mid-stream with five held entries
        r_hold = 1'b1;
        start_stream(5, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (sent[0] == 5) break;
        end
        chk("pre_rst_occ[0]", int'(occ[0]), 5);
        #1 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("mid_rst_ov[%0d]", m), int'(ov[m]), 0);
            chk($sformatf("mid_rst_occ[%0d]", m), int'(occ[m]), 0);
            chk($sformatf("mid_rst_ir[%0d]", m), int'(ir[m]), 0);
            rp[m]   = wp[m];
            hold[m] = 1'b0;
            acc[m]  = 1'b0;
            iv[m]   = 1'b0;
        end
        #6 rst_n = 1'b1;
        r_hold = 1'b0;
        @(posedge clk);
        #1;
        start_stream(8, 1'b0, 1'b0);
        run_until_done(200, "after_rst");
        chk("after_rst_rcv[0]", rcv[0], 8);
        chk("after_rst_rcv[1]", rcv[1], 8);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule
